mem_bus_responder: RTL



---
 rtl/mem_bus_responder_pkg.sv | 30 +++
 rtl/mem_bus_responder_bus_req_latch.sv | 27 ++
 rtl/mem_bus_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared types for the fetch/data memory bus responder.
// Word/pointer widths, arbiter states and the request line bundle.
package mem_bus_responder_pkg;

  typedef logic [31:0] word;
  typedef logic [29:0] ptr;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } mem_arb_state;

  typedef struct packed {
    ptr         addr;
    logic       we;
    logic [3:0] be;
    word        wdata;
  } mem_req_line;

  function automatic mem_req_line fetch_line(input ptr a);
    mem_req_line l;
    l.addr  = a;
    l.we    = 1'b0;
    l.be    = 4'b1111;
    l.wdata = '0;
    return l;
  endfunction

endpackage

// File: rtl/mem_bus_responder_bus_req_latch.sv
// Single-entry request latch: pending flag plus captured request line.
// A start while pending is dropped unless the entry is retiring this cycle.
module bus_req_latch
  import mem_bus_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  mem_req_line line_in,
  output logic        pending,
  output mem_req_line line
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
      line    <= '0;
    end else if (start && (!pending || clear)) begin
      pending <= 1'b1;
      line    <= line_in;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Round-robin responder joining the core fetch and data ports
// onto one single-ported memory request/acknowledge interface.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fetch_start,
  input  ptr         fetch_addr,
  output logic       fetch_ready,
  output word        fetch_data_rd,
  input  logic       data_start,
  input  logic       data_write,
  input  ptr         data_addr,
  input  word        data_data_wr,
  input  logic [3:0] data_data_be,
  output logic       data_ready,
  output word        data_data_rd,
  output logic       mem_req,
  output ptr         mem_addr,
  output logic       mem_we,
  output logic [3:0] mem_be,
  output word        mem_wdata,
  input  logic       mem_ack,
  input  word        mem_rdata
);

  mem_arb_state state;
  mem_arb_state last_grant;
  mem_arb_state grant;

  logic        f_pend;
  logic        d_pend;
  logic        f_clr;
  logic        d_clr;
  logic        f_elig;
  logic        d_elig;
  logic        ack_ok;
  mem_req_line f_in;
  mem_req_line d_in;
  mem_req_line f_line;
  mem_req_line d_line;
  mem_req_line f_req;
  mem_req_line d_req;

  assign ack_ok = mem_req & mem_ack;
  assign f_clr  = ack_ok & (state == FETCH);
  assign d_clr  = ack_ok & (state == DATA);

  always_comb begin
    f_in       = fetch_line(fetch_addr);
    d_in       = '0;
    d_in.addr  = data_addr;
    d_in.we    = data_write;
    d_in.be    = data_data_be;
    d_in.wdata = data_data_wr;
  end

  bus_req_latch u_fetch_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (fetch_start),
    .clear   (f_clr),
    .line_in (f_in),
    .pending (f_pend),
    .line    (f_line)
  );

  bus_req_latch u_data_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (data_start),
    .clear   (d_clr),
    .line_in (d_in),
    .pending (d_pend),
    .line    (d_line)
  );

  // A fresh start is granted straight from the port inputs;
  // a restart of the port being retired waits one cycle.
  always_comb begin
    f_elig = (f_pend | fetch_start) & ~f_clr;
    d_elig = (d_pend | data_start) & ~d_clr;
    f_req  = f_pend ? f_line : f_in;
    d_req  = d_pend ? d_line : d_in;
    grant  = IDLE;
    if (state == IDLE || ack_ok) begin
      if (f_elig && d_elig)
        grant = (last_grant == FETCH) ? DATA : FETCH;
      else if (f_elig)
        grant = FETCH;
      else if (d_elig)
        grant = DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= DATA;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_be        <= '0;
      mem_wdata     <= '0;
      fetch_ready   <= 1'b0;
      data_ready    <= 1'b0;
      fetch_data_rd <= '0;
      data_data_rd  <= '0;
    end else begin
      fetch_ready <= f_clr;
      data_ready  <= d_clr;
      if (f_clr)
        fetch_data_rd <= mem_rdata;
      if (d_clr)
        data_data_rd <= mem_we ? '0 : mem_rdata;
      if (state == IDLE || ack_ok) begin
        state   <= grant;
        mem_req <= (grant != IDLE);
        if (grant != IDLE)
          last_grant <= grant;
        unique case (grant)
          FETCH:
            {mem_addr, mem_we, mem_be, mem_wdata} <= f_req;
          DATA:
            {mem_addr, mem_we, mem_be, mem_wdata} <= d_req;
          default: ;
        endcase
      end
    end
  end

endmodule
